// File: rtl/camino_datos_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : camino_datos_multiciclo_pkg
// Purpose  : Shared encodings (phases, writeback sources, ALU ops, immediate
//            formats) and the immediate extender for the multicycle datapath.
// Revision : 1.0 - initial release
// ============================================================================
package camino_datos_multiciclo_pkg;

    typedef enum logic [2:0] {
        FASE_FETCH   = 3'd0,
        FASE_DECODE  = 3'd1,
        FASE_EXECUTE = 3'd2,
        FASE_MEM     = 3'd3,
        FASE_WB      = 3'd4
    } fase_t;

    localparam logic [1:0] c_RSC_ALU = 2'd0;
    localparam logic [1:0] c_RSC_MDR = 2'd1;
    localparam logic [1:0] c_RSC_PC4 = 2'd2;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4;
    localparam logic [2:0] c_ALU_SLT = 3'd5;
    localparam logic [2:0] c_ALU_SLL = 3'd6;
    localparam logic [2:0] c_ALU_SRL = 3'd7;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_J = 3'd3;
    localparam logic [2:0] c_IMM_U = 3'd4;

    // Returns the 32-bit sign-extended immediate; callers widen to XLEN.
    function automatic logic [31:0] extender_imm(input logic [31:0] ir,
                                                 input logic [2:0]  tipo);
        logic [31:0] imm;
        imm = '0;
        case (tipo)
            c_IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
            c_IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            c_IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            c_IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            c_IMM_U: imm = {ir[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/camino_datos_multiciclo_banco_registros.sv
`default_nettype none
// ============================================================================
// Module   : banco_registros_param
// Purpose  : NREG x XLEN register file, two async read ports plus a debug
//            read port, one synchronous write port, x0 hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module banco_registros_param
    import camino_datos_multiciclo_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] i_rs1_addr,
    input  logic [$clog2(NREG)-1:0] i_rs2_addr,
    input  logic [$clog2(NREG)-1:0] i_dbg_addr,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_wr_addr,
    input  logic [XLEN-1:0]         i_wr_data,
    output logic [XLEN-1:0]         o_rs1_data,
    output logic [XLEN-1:0]         o_rs2_data,
    output logic [XLEN-1:0]         o_dbg_data
);

    localparam int c_REG_AW = $clog2(NREG);

    logic [XLEN-1:0] w_regs [NREG];

    assign w_regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_regs
        logic [XLEN-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (i_we && (i_wr_addr == c_REG_AW'(i))) begin
                r_q <= i_wr_data;
            end
        end

        assign w_regs[i] = r_q;
    end

    assign o_rs1_data = w_regs[i_rs1_addr];
    assign o_rs2_data = w_regs[i_rs2_addr];
    assign o_dbg_data = w_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/camino_datos_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : camino_datos_multiciclo
// Purpose  : Multicycle datapath (FETCH/DECODE/EXECUTE/MEM/WB) with a shared
//            req/ack memory port, debug register read and retire pulse.
// Revision : 1.0 - initial release
// ============================================================================
module camino_datos_multiciclo
    import camino_datos_multiciclo_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk_DP,
    input  logic                    reset_DP,
    input  logic                    aluSrc_DP,
    input  logic                    regWrite_DP,
    input  logic                    memRead_DP,
    input  logic                    memWrite_DP,
    input  logic                    branch_DP,
    input  logic                    jump_DP,
    input  logic [1:0]              rscSrc_DP,
    input  logic [2:0]              aluControl_DP,
    input  logic [2:0]              type_DP,
    output logic                    mem_req_OUT,
    output logic                    mem_we_OUT,
    output logic [XLEN-1:0]         mem_addr_OUT,
    output logic [XLEN-1:0]         mem_wdata_OUT,
    input  logic [XLEN-1:0]         mem_rdata_IN,
    input  logic                    mem_ack_IN,
    input  logic [$clog2(NREG)-1:0] dbg_addr_IN,
    output logic [XLEN-1:0]         dbg_data_OUT,
    output logic [31:0]             inst_OUT,
    output logic                    zero_OUT,
    output logic [2:0]              state_OUT,
    output logic                    retire_OUT
);

    localparam int c_REG_AW  = $clog2(NREG);
    localparam int c_SHAMT_W = $clog2(XLEN);

    fase_t             r_fase;
    fase_t             w_fase_next;
    logic [XLEN-1:0]   r_pc, r_pc_old, r_a, r_b, r_alu_out, r_mdr, r_imm;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   w_rs1_data, w_rs2_data, w_src_b, w_alu_res;
    logic [XLEN-1:0]   w_wb_data, w_imm, w_pc_plus4;
    logic [c_REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic              w_retire, w_taken;

    assign w_rs1      = r_ir[15 +: c_REG_AW];
    assign w_rs2      = r_ir[20 +: c_REG_AW];
    assign w_rd       = r_ir[7 +: c_REG_AW];
    assign w_imm      = XLEN'($signed(extender_imm(r_ir, type_DP)));
    assign w_pc_plus4 = r_pc_old + XLEN'(4);
    assign w_src_b    = aluSrc_DP ? r_imm : r_b;
    assign w_taken    = jump_DP || (branch_DP && zero_OUT);

    always_comb begin : g_alu
        w_alu_res = '0;
        case (aluControl_DP)
            c_ALU_ADD: w_alu_res = r_a + w_src_b;
            c_ALU_SUB: w_alu_res = r_a - w_src_b;
            c_ALU_AND: w_alu_res = r_a & w_src_b;
            c_ALU_OR:  w_alu_res = r_a | w_src_b;
            c_ALU_XOR: w_alu_res = r_a ^ w_src_b;
            c_ALU_SLT: w_alu_res = XLEN'($signed(r_a) < $signed(w_src_b));
            c_ALU_SLL: w_alu_res = r_a << w_src_b[c_SHAMT_W-1:0];
            c_ALU_SRL: w_alu_res = r_a >> w_src_b[c_SHAMT_W-1:0];
            default:   w_alu_res = '0;
        endcase
    end

    // Reserved rscSrc code 3 falls through to ALUOut.
    always_comb begin
        w_wb_data = r_alu_out;
        case (rscSrc_DP)
            c_RSC_ALU: w_wb_data = r_alu_out;
            c_RSC_MDR: w_wb_data = r_mdr;
            c_RSC_PC4: w_wb_data = w_pc_plus4;
            default:   w_wb_data = r_alu_out;
        endcase
    end

    always_comb begin
        w_fase_next = r_fase;
        w_retire    = 1'b0;
        case (r_fase)
            FASE_FETCH: begin
                if (mem_ack_IN) w_fase_next = FASE_DECODE;
            end
            FASE_DECODE: w_fase_next = FASE_EXECUTE;
            FASE_EXECUTE: begin
                if (memRead_DP || memWrite_DP) begin
                    w_fase_next = FASE_MEM;
                end else if (regWrite_DP) begin
                    w_fase_next = FASE_WB;
                end else begin
                    w_fase_next = FASE_FETCH;
                    w_retire    = 1'b1;
                end
            end
            FASE_MEM: begin
                if (mem_ack_IN) begin
                    if (memWrite_DP) begin
                        w_fase_next = FASE_FETCH;
                        w_retire    = 1'b1;
                    end else begin
                        w_fase_next = FASE_WB;
                    end
                end
            end
            FASE_WB: begin
                w_fase_next = FASE_FETCH;
                w_retire    = 1'b1;
            end
            default: w_fase_next = FASE_FETCH;
        endcase
    end

    always_ff @(posedge clk_DP or negedge reset_DP) begin
        if (!reset_DP) begin
            r_fase <= FASE_FETCH;
        end else begin
            r_fase <= w_fase_next;
        end
    end

    always_ff @(posedge clk_DP or negedge reset_DP) begin
        if (!reset_DP) begin
            r_pc      <= RESET_PC;
            r_pc_old  <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
        end else begin
            case (r_fase)
                FASE_FETCH: begin
                    if (mem_ack_IN) begin
                        r_ir     <= mem_rdata_IN[31:0];
                        r_pc_old <= r_pc;
                    end
                end
                FASE_DECODE: begin
                    r_a   <= w_rs1_data;
                    r_b   <= w_rs2_data;
                    r_imm <= w_imm;
                end
                FASE_EXECUTE: begin
                    r_alu_out <= w_alu_res;
                    r_pc      <= w_taken ? (r_pc_old + r_imm) : w_pc_plus4;
                end
                FASE_MEM: begin
                    if (mem_ack_IN && !memWrite_DP) r_mdr <= mem_rdata_IN;
                end
                default: ;
            endcase
        end
    end

    banco_registros_param #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_banco (
        .clk        (clk_DP),
        .rst_n      (reset_DP),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .i_dbg_addr (dbg_addr_IN),
        .i_we       (r_fase == FASE_WB),
        .i_wr_addr  (w_rd),
        .i_wr_data  (w_wb_data),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data_OUT)
    );

    // Request and retire are gated by reset so nothing leaks out while held.
    assign mem_req_OUT   = reset_DP && ((r_fase == FASE_FETCH) || (r_fase == FASE_MEM));
    assign mem_we_OUT    = (r_fase == FASE_MEM) && memWrite_DP;
    assign mem_addr_OUT  = (r_fase == FASE_MEM) ? r_alu_out : r_pc;
    assign mem_wdata_OUT = r_b;
    assign retire_OUT    = reset_DP && w_retire;
    assign state_OUT     = r_fase;
    assign zero_OUT      = (w_alu_res == '0);
    assign inst_OUT      = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_camino_datos_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_camino_datos_multiciclo
// Purpose  : Directed self-checking bench for camino_datos_multiciclo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camino_datos_multiciclo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rst_w;
    logic        aluSrc, regWrite, memRead, memWrite, branch, jump;
    logic [1:0]  rscSrc;
    logic [2:0]  aluCtl, typ;
    logic        req, we, ack, zero, retire;
    logic [31:0] addr, wdata, rdata, dbg_data, inst;
    logic [4:0]  dbg_addr;
    logic [2:0]  st;

    int total = 0;
    int bad   = 0;

    // Main decoder stand-in driven from the instruction register.
    always_comb begin
        aluSrc = 1'b0; regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        branch = 1'b0; jump = 1'b0; rscSrc = 2'd0; aluCtl = 3'd0; typ = 3'd0;
        case (inst[6:0])
            7'h13: begin regWrite = 1'b1; aluSrc = 1'b1; end
            7'h03: begin regWrite = 1'b1; memRead = 1'b1; aluSrc = 1'b1; rscSrc = 2'd1; end
            7'h23: begin memWrite = 1'b1; aluSrc = 1'b1; typ = 3'd1; end
            7'h63: begin branch = 1'b1; typ = 3'd2; aluCtl = 3'd1; end
            7'h6F: begin jump = 1'b1; regWrite = 1'b1; typ = 3'd3; rscSrc = 2'd2; end
            default: ;
        endcase
    end

    // Harvard memory model: fetches zero-wait, data accesses wait data_delay.
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int   data_delay  = 0;
    int   wait_cnt    = 0;
    int   store_count = 0;
    int   cur_delay;
    logic ack_force;

    always_comb begin
        cur_delay = (st == 3'd3) ? data_delay : 0;
        ack       = (req && (wait_cnt >= cur_delay)) || ack_force;
        rdata     = (st == 3'd3) ? dmem[addr[7:2]] : imem[addr[7:2]];
    end

    always @(posedge clk) begin
        if (req && we && ack) begin
            dmem[addr[7:2]] <= wdata;
            store_count     <= store_count + 1;
        end
        if (!req || ack) wait_cnt <= 0;
        else             wait_cnt <= wait_cnt + 1;
    end

    camino_datos_multiciclo #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) dut (
        .clk_DP(clk), .reset_DP(reset_n),
        .aluSrc_DP(aluSrc), .regWrite_DP(regWrite), .memRead_DP(memRead),
        .memWrite_DP(memWrite), .branch_DP(branch), .jump_DP(jump),
        .rscSrc_DP(rscSrc), .aluControl_DP(aluCtl), .type_DP(typ),
        .mem_req_OUT(req), .mem_we_OUT(we), .mem_addr_OUT(addr),
        .mem_wdata_OUT(wdata), .mem_rdata_IN(rdata), .mem_ack_IN(ack),
        .dbg_addr_IN(dbg_addr), .dbg_data_OUT(dbg_data), .inst_OUT(inst),
        .zero_OUT(zero), .state_OUT(st), .retire_OUT(retire)
    );

    // Two instances parked near the top of the address space executing jal x1,+16.
    logic        wa_req, wa_we, wa_zero, wa_ret, wb_req, wb_we, wb_zero, wb_ret;
    logic [31:0] wa_addr, wa_wd, wa_dbg, wa_inst, wb_addr, wb_wd, wb_dbg, wb_inst;
    logic [2:0]  wa_st, wb_st;

    camino_datos_multiciclo #(.XLEN(32), .NREG(32), .RESET_PC(32'h7FFF_FFFC)) dut_wa (
        .clk_DP(clk), .reset_DP(rst_w),
        .aluSrc_DP(1'b0), .regWrite_DP(1'b1), .memRead_DP(1'b0),
        .memWrite_DP(1'b0), .branch_DP(1'b0), .jump_DP(1'b1),
        .rscSrc_DP(2'd2), .aluControl_DP(3'd0), .type_DP(3'd3),
        .mem_req_OUT(wa_req), .mem_we_OUT(wa_we), .mem_addr_OUT(wa_addr),
        .mem_wdata_OUT(wa_wd), .mem_rdata_IN(32'h0100_00EF), .mem_ack_IN(wa_req),
        .dbg_addr_IN(5'd1), .dbg_data_OUT(wa_dbg), .inst_OUT(wa_inst),
        .zero_OUT(wa_zero), .state_OUT(wa_st), .retire_OUT(wa_ret)
    );

    camino_datos_multiciclo #(.XLEN(32), .NREG(32), .RESET_PC(32'hFFFF_FFFC)) dut_wb (
        .clk_DP(clk), .reset_DP(rst_w),
        .aluSrc_DP(1'b0), .regWrite_DP(1'b1), .memRead_DP(1'b0),
        .memWrite_DP(1'b0), .branch_DP(1'b0), .jump_DP(1'b1),
        .rscSrc_DP(2'd2), .aluControl_DP(3'd0), .type_DP(3'd3),
        .mem_req_OUT(wb_req), .mem_we_OUT(wb_we), .mem_addr_OUT(wb_addr),
        .mem_wdata_OUT(wb_wd), .mem_rdata_IN(32'h0100_00EF), .mem_ack_IN(wb_req),
        .dbg_addr_IN(5'd1), .dbg_data_OUT(wb_dbg), .inst_OUT(wb_inst),
        .zero_OUT(wb_zero), .state_OUT(wb_st), .retire_OUT(wb_ret)
    );

    logic [2:0]  st_log   [32];
    logic        req_log  [32];
    logic        we_log   [32];
    logic        ack_log  [32];
    logic        zero_log [32];
    logic [31:0] addr_log [32];
    logic [31:0] wd_log   [32];

    // Logs one instruction cycle by cycle; cyc is 0 when the budget expires.
    task automatic run_instr(input int max, output int cyc);
        cyc = 0;
        for (int i = 0; i < max && i < 32; i++) begin
            st_log[i] = st;     req_log[i] = req;   we_log[i] = we;
            ack_log[i] = ack;   zero_log[i] = zero;
            addr_log[i] = addr; wd_log[i] = wdata;
            if (retire) begin
                cyc = i + 1;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rst_w = 1'b0; ack_force = 1'b0; dbg_addr = 5'd1;
        repeat (3) @(negedge clk);
        total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", req); end
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL reset_retire got=%0b want=0", retire); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h want=0", inst); end
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL reset_x1 got=%h want=0", dbg_data); end
        reset_n = 1'b1;
        #1;
        total++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h0) begin
            bad++; $display("FAIL reset_first_fetch got req=%0b we=%0b addr=%h want 1 0 0", req, we, addr);
        end
    endtask

    task automatic test_addi();
        int cyc;
        run_instr(20, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL addi_cycles got=%0d want=4", cyc); end
        total++; if ({st_log[0], st_log[1], st_log[2], st_log[3]} !== {3'd0, 3'd1, 3'd2, 3'd4}) begin
            bad++; $display("FAIL addi_states got=%0d,%0d,%0d,%0d want=0,1,2,4", st_log[0], st_log[1], st_log[2], st_log[3]);
        end
        total++; if (inst !== 32'h0050_0093) begin bad++; $display("FAIL addi_ir got=%h want=00500093", inst); end
        dbg_addr = 5'd1; #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL addi_x1 got=%h want=5", dbg_data); end
        total++; if (st !== 3'd0 || addr !== 32'h4) begin bad++; $display("FAIL addi_pc got st=%0d addr=%h want 0 4", st, addr); end
    endtask

    task automatic test_store_load();
        int cyc;
        int held;
        data_delay = 3;
        run_instr(30, cyc);
        total++; if (cyc !== 7) begin bad++; $display("FAIL sw_cycles got=%0d want=7", cyc); end
        held = 0;
        for (int i = 0; i < 32; i++)
            if (i < cyc && st_log[i] == 3'd3 && !ack_log[i] && req_log[i] && we_log[i] &&
                addr_log[i] == 32'd8 && wd_log[i] == 32'd5) held++;
        total++; if (held !== 3) begin bad++; $display("FAIL sw_held got=%0d want=3", held); end
        total++; if (store_count !== 1 || dmem[2] !== 32'd5) begin
            bad++; $display("FAIL sw_mem got count=%0d data=%h want 1 5", store_count, dmem[2]);
        end
        run_instr(30, cyc);
        total++; if (cyc !== 8) begin bad++; $display("FAIL lw_cycles got=%0d want=8", cyc); end
        held = 0;
        for (int i = 0; i < 32; i++)
            if (i < cyc && st_log[i] == 3'd3 && req_log[i] && !we_log[i] && addr_log[i] == 32'd8) held++;
        total++; if (held !== 4) begin bad++; $display("FAIL lw_read_cycles got=%0d want=4", held); end
        dbg_addr = 5'd2; #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL lw_x2 got=%h want=5", dbg_data); end
        total++; if (addr !== 32'hC) begin bad++; $display("FAIL lw_pc got=%h want=c", addr); end
        data_delay = 0;
    endtask

    task automatic test_x0_write();
        int cyc;
        run_instr(20, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL x0_retire got=%0d want=4", cyc); end
        dbg_addr = 5'd0; #1;
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL x0_value got=%h want=0", dbg_data); end
        total++; if (addr !== 32'h10) begin bad++; $display("FAIL x0_pc got=%h want=10", addr); end
    endtask

    task automatic test_branch();
        int cyc;
        run_instr(20, cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL beq_cycles got=%0d want=3", cyc); end
        total++; if (st_log[2] !== 3'd2 || zero_log[2] !== 1'b1) begin
            bad++; $display("FAIL beq_zero got st=%0d zero=%0b want 2 1", st_log[2], zero_log[2]);
        end
        total++; if (addr !== 32'hC || st !== 3'd0) begin bad++; $display("FAIL beq_target got=%h want=c", addr); end
        dbg_addr = 5'd1; #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL beq_no_wb got x1=%h want=5", dbg_data); end
    endtask

    task automatic test_reset_mid_mem();
        int cyc;
        int saved;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(20, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL restart_addi got=%0d want=4", cyc); end
        data_delay = 20;
        saved = store_count;
        for (int i = 0; i < 10; i++) begin
            if (st == 3'd3) break;
            @(posedge clk); @(negedge clk);
        end
        repeat (2) begin @(posedge clk); @(negedge clk); end
        total++; if (st !== 3'd3 || req !== 1'b1 || retire !== 1'b0) begin
            bad++; $display("FAIL mem_wait got st=%0d req=%0b ret=%0b want 3 1 0", st, req, retire);
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if (st !== 3'd0 || req !== 1'b0 || retire !== 1'b0) begin
            bad++; $display("FAIL async_reset got st=%0d req=%0b ret=%0b want 0 0 0", st, req, retire);
        end
        @(negedge clk); ack_force = 1'b1;
        @(negedge clk); ack_force = 1'b0; reset_n = 1'b1;
        dbg_addr = 5'd1; #1;
        total++; if (st !== 3'd0 || addr !== 32'h0) begin bad++; $display("FAIL reset_pc got st=%0d addr=%h want 0 0", st, addr); end
        total++; if (store_count !== saved) begin bad++; $display("FAIL stray_store got=%0d want=%0d", store_count, saved); end
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL reset_regs got x1=%h want=0", dbg_data); end
        data_delay = 0;
        run_instr(20, cyc);
        total++; if (cyc !== 4 || addr !== 32'h4) begin bad++; $display("FAIL post_reset got cyc=%0d addr=%h want 4 4", cyc, addr); end
    endtask

    task automatic test_jal_wrap();
        int cyc;
        @(negedge clk);
        rst_w = 1'b1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (wa_ret) begin
                cyc = i + 1;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        total++; if (cyc !== 4 || wb_ret !== 1'b1) begin bad++; $display("FAIL jal_cycles got=%0d/%0b want 4/1", cyc, wb_ret); end
        @(posedge clk); @(negedge clk);
        total++; if (wa_dbg !== 32'h8000_0000) begin bad++; $display("FAIL jal_link got=%h want=80000000", wa_dbg); end
        total++; if (wa_addr !== 32'h8000_000C || wa_st !== 3'd0) begin bad++; $display("FAIL jal_target got=%h want=8000000c", wa_addr); end
        total++; if (wb_dbg !== 32'h0) begin bad++; $display("FAIL jal_wrap_link got=%h want=0", wb_dbg); end
        total++; if (wb_addr !== 32'hC || wb_st !== 3'd0) begin bad++; $display("FAIL jal_wrap_target got=%h want=c", wb_addr); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0] = 32'h0050_0093;  // addi x1,x0,5
        imem[1] = 32'h0010_2423;  // sw   x1,8(x0)
        imem[2] = 32'h0080_2103;  // lw   x2,8(x0)
        imem[3] = 32'h0070_0013;  // addi x0,x0,7
        imem[4] = 32'hFE00_0EE3;  // beq  x0,x0,-4
        test_reset();
        test_addi();
        test_store_load();
        test_x0_write();
        test_branch();
        test_reset_mid_mem();
        test_jal_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
